// File: rtl/decl_stmt_check_pkg.sv
// Shared types and character-class helpers for the declaration-statement checker.
// The ARR_* states exist only when ARRAY_DECL_EN is defined.
package decl_stmt_check_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_KW      = 4'd1,
      ST_KW_SP   = 4'd2,
      ST_PRE_ID  = 4'd3,
      ST_ID      = 4'd4,
      ST_POST_ID = 4'd5,
      ST_ERR     = 4'd6
`ifdef ARRAY_DECL_EN
      ,
      ST_ARR_NUM = 4'd7,
      ST_ARR_END = 4'd8
`endif
   } state_t;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_TAB   = 8'h09;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_COMMA = 8'h2C;
   localparam logic [7:0] CH_SEMI  = 8'h3B;
   localparam logic [7:0] CH_LBRK  = 8'h5B;
   localparam logic [7:0] CH_RBRK  = 8'h5D;

   function automatic logic is_ws(input logic [7:0] c);
      return (c == CH_SPACE) || (c == CH_TAB) || (c == CH_CR) || (c == CH_LF);
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   function automatic logic is_id_start(input logic [7:0] c);
      return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h5F);
   endfunction

   function automatic logic is_id_body(input logic [7:0] c);
      return is_id_start(c) || is_digit(c);
   endfunction

   // Expected character at position pos of "int" (sel_char=0) or "char" (sel_char=1).
   function automatic logic [7:0] kw_char(input logic sel_char, input logic [2:0] pos);
      logic [7:0] c;
      c = 8'h00;
      if (sel_char) begin
         case (pos)
            3'd0: c = 8'h63;
            3'd1: c = 8'h68;
            3'd2: c = 8'h61;
            3'd3: c = 8'h72;
            default: c = 8'h00;
         endcase
      end else begin
         case (pos)
            3'd0: c = 8'h69;
            3'd1: c = 8'h6E;
            3'd2: c = 8'h74;
            default: c = 8'h00;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/decl_stmt_check_if.sv
// Character-in / verdict-out bundle between a character source and the checker.
interface decl_stmt_check_if #(
   parameter int CNT_W = 4
);
   logic [7:0]       in;
   logic             in_valid;
   logic             out;
   logic             bad;
   logic [CNT_W-1:0] var_count;

   modport master (output in, in_valid, input out, bad, var_count);
   modport slave  (input in, in_valid, output out, bad, var_count);
endinterface

// File: rtl/decl_kw_tracker.sv
// Prefix tracker for the keywords "int" and "char"; restarted on the first character
// of each keyword or identifier, advanced on every following one.
module decl_kw_tracker
   import decl_stmt_check_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       step,
   input  logic [7:0] ch,
   output logic       kw_done,
   output logic       kw_fail,
   output logic       is_kw
);

   logic [2:0] pos, pos_n;
   logic       m_int, m_char, n_int, n_char;

   // NOTE: every signal assigned here gets a default first, so no latch is inferred.
   always_comb begin
      pos_n  = pos;
      n_int  = m_int;
      n_char = m_char;
      if (start) begin
         n_int  = (ch == kw_char(1'b0, 3'd0));
         n_char = (ch == kw_char(1'b1, 3'd0));
         pos_n  = 3'd1;
      end else if (step) begin
         n_int  = m_int  && (pos < 3'd3) && (ch == kw_char(1'b0, pos));
         n_char = m_char && (pos < 3'd4) && (ch == kw_char(1'b1, pos));
         pos_n  = (pos == 3'd7) ? pos : pos + 3'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos    <= 3'd0;
         m_int  <= 1'b0;
         m_char <= 1'b0;
      end else if (start || step) begin
         pos    <= pos_n;
         m_int  <= n_int;
         m_char <= n_char;
      end
   end

   // kw_done/kw_fail describe the character being consumed; is_kw describes what is already stored.
   assign kw_done = (n_int && (pos_n == 3'd3)) || (n_char && (pos_n == 3'd4));
   assign kw_fail = !(n_int || n_char);
   assign is_kw   = (m_int && (pos == 3'd3)) || (m_char && (pos == 3'd4));

endmodule

// File: rtl/decl_stmt_check.sv
// Byte-serial checker for "<int|char> <decl>{,<decl>};" statements with declarator count.
// Define ARRAY_DECL_EN to accept array declarators of the form name[digits].
module decl_stmt_check
   import decl_stmt_check_pkg::*;
#(
   parameter int MAX_ID_LEN = 16,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   decl_stmt_check_if.slave  bus
);

   localparam logic [8:0] MAX_LEN9 = 9'(MAX_ID_LEN);

   state_t           state, state_n;
   logic [7:0]       len;
   logic [8:0]       len_sum;
   logic [CNT_W-1:0] count, var_count_q;
   logic             out_q, bad_q;
   logic             pulse_out, pulse_bad;
   logic             len_load, len_inc, cnt_inc;
   logic             kw_start, kw_step, kw_done, kw_fail, is_kw;
   logic [7:0]       c;
   logic             id_end;
`ifdef ARRAY_DECL_EN
   logic             arr_seen, arr_clear, arr_set;
`endif

   assign c       = bus.in;
   assign len_sum = {1'b0, len} + 9'd1;

`ifdef ARRAY_DECL_EN
   assign id_end = is_ws(c) || (c == CH_COMMA) || (c == CH_SEMI) || (c == CH_LBRK);
`else
   assign id_end = is_ws(c) || (c == CH_COMMA) || (c == CH_SEMI);
`endif

   decl_kw_tracker u_kw (
      .clk     (clk),
      .reset   (reset),
      .start   (kw_start),
      .step    (kw_step),
      .ch      (c),
      .kw_done (kw_done),
      .kw_fail (kw_fail),
      .is_kw   (is_kw)
   );

   always_comb begin
      state_n   = state;
      pulse_out = 1'b0;
      pulse_bad = 1'b0;
      len_load  = 1'b0;
      len_inc   = 1'b0;
      cnt_inc   = 1'b0;
      kw_start  = 1'b0;
      kw_step   = 1'b0;
`ifdef ARRAY_DECL_EN
      arr_clear = 1'b0;
      arr_set   = 1'b0;
`endif
      if (bus.in_valid) begin
         case (state)
            ST_IDLE: begin
               if (is_ws(c) || (c == CH_SEMI)) state_n = ST_IDLE;
               else if ((c == kw_char(1'b0, 3'd0)) || (c == kw_char(1'b1, 3'd0))) begin
                  kw_start = 1'b1;
                  state_n  = ST_KW;
               end else state_n = ST_ERR;
            end
            ST_KW: begin
               kw_step = 1'b1;
               if (kw_fail)      state_n = ST_ERR;
               else if (kw_done) state_n = ST_KW_SP;
            end
            ST_KW_SP: state_n = is_ws(c) ? ST_PRE_ID : ST_ERR;
            ST_PRE_ID: begin
               if (is_id_start(c)) begin
                  kw_start = 1'b1;
                  len_load = 1'b1;
                  cnt_inc  = 1'b1;
                  state_n  = ST_ID;
               end else if (!is_ws(c)) state_n = ST_ERR;
            end
            ST_ID: begin
               if (is_id_body(c)) begin
                  kw_step = 1'b1;
                  len_inc = 1'b1;
                  if (len_sum > MAX_LEN9) state_n = ST_ERR;
               end else if (id_end && !is_kw) begin
                  if (is_ws(c))            state_n = ST_POST_ID;
                  else if (c == CH_COMMA)  state_n = ST_PRE_ID;
                  else if (c == CH_SEMI) begin
                     state_n   = ST_IDLE;
                     pulse_out = 1'b1;
                  end
`ifdef ARRAY_DECL_EN
                  else begin
                     arr_clear = 1'b1;
                     state_n   = ST_ARR_NUM;
                  end
`endif
               end else state_n = ST_ERR;
            end
`ifdef ARRAY_DECL_EN
            ST_ARR_NUM: begin
               if (is_digit(c))                        arr_set = 1'b1;
               else if ((c == CH_RBRK) && arr_seen)     state_n = ST_ARR_END;
               else                                     state_n = ST_ERR;
            end
            ST_POST_ID, ST_ARR_END: begin
`else
            ST_POST_ID: begin
`endif
               if (c == CH_COMMA) state_n = ST_PRE_ID;
               else if (c == CH_SEMI) begin
                  state_n   = ST_IDLE;
                  pulse_out = 1'b1;
               end else if (!is_ws(c)) state_n = ST_ERR;
            end
            ST_ERR:  state_n = ST_ERR;
            default: state_n = ST_ERR;
         endcase
         // A ';' that would land in ERR terminates the statement as rejected.
         if ((c == CH_SEMI) && (state_n == ST_ERR)) begin
            state_n   = ST_IDLE;
            pulse_bad = 1'b1;
         end
      end
   end

   // NOTE: reset clears every register here; this block holds no memory arrays.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         len         <= 8'd0;
         count       <= '0;
         var_count_q <= '0;
         out_q       <= 1'b0;
         bad_q       <= 1'b0;
      end else begin
         out_q <= pulse_out;
         bad_q <= pulse_bad;
         if (pulse_out) var_count_q <= count;
         if (bus.in_valid) begin
            state <= state_n;
            if (state_n == ST_IDLE) begin
               len   <= 8'd0;
               count <= '0;
            end else begin
               if (len_load)     len <= 8'd1;
               else if (len_inc) len <= len_sum[8] ? 8'hFF : len_sum[7:0];
               if (cnt_inc && (count != '1)) count <= count + CNT_W'(1);
            end
         end
      end
   end

`ifdef ARRAY_DECL_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          arr_seen <= 1'b0;
      else if (bus.in_valid && arr_clear) arr_seen <= 1'b0;
      else if (bus.in_valid && arr_set)   arr_seen <= 1'b1;
   end
`endif

   assign bus.out       = out_q;
   assign bus.bad       = bad_q;
   assign bus.var_count = var_count_q;

endmodule
